dff_bank_arbiter: RTL

Shares one bank of DEPTH W-bit D-type registers between N_REQ write requesters. Each register has async clear and a sync set-to-ones function. A round-robin arbiter and a two-state write sequencer grant one requester at a time, capture its address and data, and commit the word. The full bank is exported flat to downstream logic. It sits between control-slave front-ends and the configuration/status register fabric.

---
 rtl/dff_bank_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/dff_bank_arbiter.sv
// Shared DEPTH x W register bank written by N_REQ requesters through a round-robin arbiter and IDLE/WRITE sequencer.
// Optional burst lock enabled by defining ARB_LOCK_EN (adds the lock input).
module dff_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 tt,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*AW-1:0]  addr,
  input  logic [N_REQ*W-1:0]   wdata,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]     lock,
`endif
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic [DEPTH*W-1:0]   q
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   laddr;
  logic [W-1:0]    ldata;
  logic [W-1:0]    bank [DEPTH];

  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   next_last;

  // Scan from farthest to nearest so the requester closest after last wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'((int'(last) + k) % N_REQ);
      end
    end
  end

`ifdef ARB_LOCK_EN
  // Pointing last just before the grantee keeps it on top for the next round.
  always_comb begin
    next_last = idx;
    if (lock[idx])
      next_last = (idx == '0) ? IW'(N_REQ - 1) : idx - 1'b1;
  end
`else
  assign next_last = idx;
`endif

  always_comb begin
    ack = '0;
    if (state == WRITE && tt)
      ack[idx] = 1'b1;
  end

  assign busy = (state == WRITE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      last  <= IW'(N_REQ - 1);
      idx   <= '0;
      laddr <= '0;
      ldata <= '0;
      for (int k = 0; k < DEPTH; k++)
        bank[k] <= '0;
    end else if (!tt) begin
      // Preset wins over any write in flight; the requester is re-arbitrated.
      state <= IDLE;
      for (int k = 0; k < DEPTH; k++)
        bank[k] <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            idx   <= gnt_idx;
            laddr <= addr[int'(gnt_idx)*AW +: AW];
            ldata <= wdata[int'(gnt_idx)*W +: W];
            state <= WRITE;
          end
        end
        WRITE: begin
          bank[laddr] <= ldata;
          last        <= next_last;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_q
    assign q[k*W +: W] = bank[k];
  end

endmodule
